// File: rtl/lsu_mem_master_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_master_if
//   Bundles the execute-stage request/response handshake and the data-memory
//   enable/cmd/valid bus that lsu_mem_master sits between.
//
//   Request side  : req_valid/req_ready handshake, req_we, req_funct3,
//                   req_addr, req_wdata.
//   Response side : resp_valid pulse, resp_rdata, resp_misaligned,
//                   resp_timeout.
//   Memory side   : mem_addr, mem_mask, mem_enable, mem_cmd, mem_write_data
//                   toward the memory; mem_load_data, mem_valid back.
//
//   modport master : the load/store unit (lsu_mem_master).
//   modport slave  : everything around it (execute stage + memory).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface lsu_mem_master_if;
    // Execute-stage request
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // Execute-stage response
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_timeout;

    // Data-memory bus
    logic [31:0] mem_addr;
    logic [3:0]  mem_mask;
    logic        mem_enable;
    logic        mem_cmd;
    logic [31:0] mem_write_data;
    logic [31:0] mem_load_data;
    logic        mem_valid;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_misaligned, resp_timeout,
        output mem_addr, mem_mask, mem_enable, mem_cmd, mem_write_data,
        input  mem_load_data, mem_valid
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_misaligned, resp_timeout,
        input  mem_addr, mem_mask, mem_enable, mem_cmd, mem_write_data,
        output mem_load_data, mem_valid
    );
endinterface

// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
//   Load/store initiator for the RV32I data-memory port. Accepts one load or
//   store per req_valid/req_ready handshake, drives the enable/cmd/valid
//   memory protocol with a word address, byte mask and lane-replicated store
//   data, and returns sign/zero-extended load data with a one-cycle
//   resp_valid pulse. Misaligned/illegal requests never touch the memory;
//   a memory that stays silent for TIMEOUT_CYCLES cycles is abandoned.
//
// Parameters
//   TIMEOUT_CYCLES : REQ cycles without mem_valid before giving up (1..65535)
//
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : lsu_mem_master_if.master (request, response and memory signals)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module lsu_mem_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    lsu_mem_master_if.master      bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Compared against the incremented 17-bit count so that the maximum
    // setting of 65535 cannot wrap the 16-bit counter.
    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

    logic [1:0]  state_q,        state_d;
    logic        req_ready_q,    req_ready_d;
    logic [2:0]  funct3_q,       funct3_d;
    logic [1:0]  byte_off_q,     byte_off_d;
    logic [15:0] cnt_q,          cnt_d;
    logic        mem_enable_q,   mem_enable_d;
    logic        mem_cmd_q,      mem_cmd_d;
    logic [31:0] mem_addr_q,     mem_addr_d;
    logic [3:0]  mem_mask_q,     mem_mask_d;
    logic [31:0] mem_wdata_q,    mem_wdata_d;
    logic        resp_valid_q,   resp_valid_d;
    logic [31:0] resp_rdata_q,   resp_rdata_d;
    logic        resp_mis_q,     resp_mis_d;
    logic        resp_to_q,      resp_to_d;

    // -------------------------------------------------------------------------
    // Incoming request decode: legality, byte mask, store-lane replication
    // -------------------------------------------------------------------------
    logic        req_illegal;
    logic [3:0]  req_mask;
    logic [31:0] req_wdata_rep;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the case statements can leave it unassigned and infer
    // a latch.
    always_comb begin
        req_illegal   = 1'b0;
        req_mask      = 4'b1111;
        req_wdata_rep = 32'd0;

        unique case (bus.req_funct3)
            F3_B, F3_BU: req_mask = 4'b0001 << bus.req_addr[1:0];
            F3_H, F3_HU: begin
                req_mask    = 4'b0011 << bus.req_addr[1:0];
                req_illegal = bus.req_addr[0];
            end
            F3_W:        req_illegal = (bus.req_addr[1:0] != 2'b00);
            default:     req_illegal = 1'b1;
        endcase

        // Unsigned widths only exist for loads.
        if (bus.req_we && (bus.req_funct3 == F3_BU || bus.req_funct3 == F3_HU)) begin
            req_illegal = 1'b1;
        end

        // Loads leave the write-data lanes quiet.
        if (bus.req_we) begin
            unique case (bus.req_funct3)
                F3_B:    req_wdata_rep = {4{bus.req_wdata[7:0]}};
                F3_H:    req_wdata_rep = {2{bus.req_wdata[15:0]}};
                default: req_wdata_rep = bus.req_wdata;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Load extraction: align the addressed byte/half to bit 0, then extend
    // -------------------------------------------------------------------------
    logic [31:0] load_shifted;
    logic [31:0] load_ext;

    always_comb begin
        load_shifted = bus.mem_load_data >> {byte_off_q, 3'b000};
        load_ext     = load_shifted;
        unique case (funct3_q)
            F3_B:    load_ext = {{24{load_shifted[7]}},  load_shifted[7:0]};
            F3_BU:   load_ext = {24'd0,                  load_shifted[7:0]};
            F3_H:    load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
            F3_HU:   load_ext = {16'd0,                  load_shifted[15:0]};
            default: load_ext = load_shifted;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic [16:0] cnt_inc;
    assign cnt_inc = {1'b0, cnt_q} + 17'd1;

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        funct3_d     = funct3_q;
        byte_off_d   = byte_off_q;
        cnt_d        = cnt_q;
        mem_enable_d = mem_enable_q;
        mem_cmd_d    = mem_cmd_q;
        mem_addr_d   = mem_addr_q;
        mem_mask_d   = mem_mask_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;          // pulse: only raised on the entry edge
        resp_rdata_d = resp_rdata_q;  // response fields hold until the next one
        resp_mis_d   = resp_mis_q;
        resp_to_d    = resp_to_q;

        unique case (state_q)
            ST_IDLE: begin
                // Ready comes up on the first edge after reset release.
                req_ready_d = 1'b1;
                if (req_ready_q && bus.req_valid) begin
                    req_ready_d = 1'b0;
                    funct3_d    = bus.req_funct3;
                    byte_off_d  = bus.req_addr[1:0];
                    mem_cmd_d   = bus.req_we;
                    if (req_illegal) begin
                        // Memory is never enabled; answer directly.
                        state_d      = ST_RELEASE;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'd0;
                        resp_mis_d   = 1'b1;
                        resp_to_d    = 1'b0;
                    end else begin
                        state_d      = ST_REQ;
                        cnt_d        = 16'd0;
                        mem_enable_d = 1'b1;
                        mem_addr_d   = {bus.req_addr[31:2], 2'b00};
                        mem_mask_d   = req_mask;
                        mem_wdata_d  = req_wdata_rep;
                    end
                end
            end

            ST_REQ: begin
                cnt_d = cnt_inc[15:0];
                // mem_valid is tested first so it wins over a coincident timeout.
                if (bus.mem_valid) begin
                    state_d      = ST_RELEASE;
                    mem_enable_d = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_cmd_q ? 32'd0 : load_ext;
                    resp_mis_d   = 1'b0;
                    resp_to_d    = 1'b0;
                end else if (cnt_inc == TIMEOUT_LIMIT) begin
                    // Count of enable-high cycles so far equals cnt_q + 1.
                    state_d      = ST_RELEASE;
                    mem_enable_d = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 32'd0;
                    resp_mis_d   = 1'b0;
                    resp_to_d    = 1'b1;
                end
            end

            ST_RELEASE: begin
                // Wait for the memory to drop mem_valid before taking new work.
                if (!bus.mem_valid) begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                mem_enable_d = 1'b0;
                req_ready_d  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            funct3_q     <= 3'd0;
            byte_off_q   <= 2'd0;
            cnt_q        <= 16'd0;
            mem_enable_q <= 1'b0;
            mem_cmd_q    <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_mask_q   <= 4'd0;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_mis_q   <= 1'b0;
            resp_to_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            funct3_q     <= funct3_d;
            byte_off_q   <= byte_off_d;
            cnt_q        <= cnt_d;
            mem_enable_q <= mem_enable_d;
            mem_cmd_q    <= mem_cmd_d;
            mem_addr_q   <= mem_addr_d;
            mem_mask_q   <= mem_mask_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
            resp_to_q    <= resp_to_d;
        end
    end

    // All outputs come straight from registers.
    assign bus.req_ready       = req_ready_q;
    assign bus.mem_enable      = mem_enable_q;
    assign bus.mem_cmd         = mem_cmd_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_mask        = mem_mask_q;
    assign bus.mem_write_data  = mem_wdata_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.resp_misaligned = resp_mis_q;
    assign bus.resp_timeout    = resp_to_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_master
//   Directed bench for lsu_mem_master. The stimulus process issues requests
//   and plays the memory; each request pushes its hand-computed response onto
//   a queue, and an independent monitor pops and compares whenever resp_valid
//   is seen. Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_lsu_mem_master;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lsu_mem_master_if bus ();

    lsu_mem_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
        logic        to;
    } resp_t;

    resp_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Response monitor / scoreboard
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(bus.resp_valid), 32'd0);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                check("resp_rdata",      bus.resp_rdata,            e.rdata);
                check("resp_misaligned", 32'(bus.resp_misaligned),  32'(e.mis));
                check("resp_timeout",    32'(bus.resp_timeout),     32'(e.to));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    // Hands one request over; returns at the falling edge of the first cycle
    // after the handshake edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit push, input resp_t e);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("ready_wait", 32'(bus.req_ready), 32'd1);
        if (push) exp_q.push_back(e);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        bus.req_valid  = 1'b0;
    endtask

    task automatic check_mem(input string tag, input logic cmd, input logic [31:0] addr,
                             input logic [3:0] mask, input logic [31:0] wdata);
        check({tag, "_enable"}, 32'(bus.mem_enable), 32'd1);
        check({tag, "_cmd"},    32'(bus.mem_cmd),    32'(cmd));
        check({tag, "_addr"},   bus.mem_addr,        addr);
        check({tag, "_mask"},   32'(bus.mem_mask),   32'(mask));
        if (cmd) check({tag, "_wdata"}, bus.mem_write_data, wdata);
    endtask

    // Acts as the memory: answers so mem_enable is high for exactly `lat`
    // cycles, then holds mem_valid `hold` extra cycles into RELEASE.
    task automatic serve(input string tag, input int lat, input int hold,
                         input logic [31:0] word);
        int          en_cnt = 0;
        bit          stable = 1'b1;
        logic [31:0] a0     = bus.mem_addr;
        logic [3:0]  m0     = bus.mem_mask;
        logic [31:0] w0     = bus.mem_write_data;
        logic        c0     = bus.mem_cmd;
        for (int i = 1; i <= lat; i++) begin
            if (bus.mem_enable === 1'b1) en_cnt++;
            if (bus.mem_addr !== a0 || bus.mem_mask !== m0 ||
                bus.mem_write_data !== w0 || bus.mem_cmd !== c0) stable = 1'b0;
            if (i == lat) begin
                bus.mem_valid     = 1'b1;
                bus.mem_load_data = word;
            end
            @(negedge clk);
        end
        check({tag, "_enable_cycles"}, 32'(en_cnt), 32'(lat));
        check({tag, "_mem_stable"},    32'(stable), 32'd1);
        check({tag, "_enable_drop"},   32'(bus.mem_enable), 32'd0);
        for (int i = 0; i < hold; i++) begin
            check({tag, "_ready_hold"}, 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        check({tag, "_ready_low"}, 32'(bus.req_ready), 32'd0);
        bus.mem_valid     = 1'b0;
        bus.mem_load_data = 32'd0;
        @(negedge clk);
        check({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic illegal(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr);
        issue(we, f3, addr, 32'hFFFF_FFFF, 1'b1, '{rdata: 32'd0, mis: 1'b1, to: 1'b0});
        check({tag, "_no_enable"}, 32'(bus.mem_enable), 32'd0);
        check({tag, "_ready_low"}, 32'(bus.req_ready),  32'd0);
        @(negedge clk);
        check({tag, "_no_enable2"}, 32'(bus.mem_enable), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.req_ready),  32'd1);
    endtask

    localparam resp_t OK0 = '{rdata: 32'd0, mis: 1'b0, to: 1'b0};

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        int en_cnt;

        reset             = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_we        = 1'b0;
        bus.req_funct3    = 3'd0;
        bus.req_addr      = 32'd0;
        bus.req_wdata     = 32'd0;
        bus.mem_valid     = 1'b0;
        bus.mem_load_data = 32'd0;

        repeat (2) @(negedge clk);
        check("rst_ready",      32'(bus.req_ready),      32'd0);
        check("rst_enable",     32'(bus.mem_enable),     32'd0);
        check("rst_cmd",        32'(bus.mem_cmd),        32'd0);
        check("rst_addr",       bus.mem_addr,            32'd0);
        check("rst_mask",       32'(bus.mem_mask),       32'd0);
        check("rst_wdata",      bus.mem_write_data,      32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid),     32'd0);
        check("rst_resp_rdata", bus.resp_rdata,          32'd0);
        check("rst_resp_flags", {30'd0, bus.resp_misaligned, bus.resp_timeout}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready_after", 32'(bus.req_ready), 32'd1);

        // SW, five-cycle memory
        issue(1'b1, 3'b010, 32'h0000_0010, 32'h0000_FFFF, 1'b1, OK0);
        check_mem("sw", 1'b1, 32'h0000_0010, 4'b1111, 32'h0000_FFFF);
        serve("sw", 5, 0, 32'h0);

        // LB / LBU / LH / LHU from word 0x80FF7F01
        issue(1'b0, 3'b000, 32'h0000_0013, 32'h0, 1'b1, '{rdata: 32'hFFFF_FF80, mis: 1'b0, to: 1'b0});
        check_mem("lb", 1'b0, 32'h0000_0010, 4'b1000, 32'h0);
        serve("lb", 1, 0, 32'h80FF_7F01);

        issue(1'b0, 3'b100, 32'h0000_0013, 32'h0, 1'b1, '{rdata: 32'h0000_0080, mis: 1'b0, to: 1'b0});
        check_mem("lbu", 1'b0, 32'h0000_0010, 4'b1000, 32'h0);
        serve("lbu", 2, 0, 32'h80FF_7F01);

        issue(1'b0, 3'b001, 32'h0000_0012, 32'h0, 1'b1, '{rdata: 32'hFFFF_80FF, mis: 1'b0, to: 1'b0});
        check_mem("lh", 1'b0, 32'h0000_0010, 4'b1100, 32'h0);
        serve("lh", 1, 0, 32'h80FF_7F01);

        issue(1'b0, 3'b101, 32'h0000_0012, 32'h0, 1'b1, '{rdata: 32'h0000_80FF, mis: 1'b0, to: 1'b0});
        check_mem("lhu", 1'b0, 32'h0000_0010, 4'b1100, 32'h0);
        serve("lhu", 1, 0, 32'h80FF_7F01);

        // SH / SB lane replication
        issue(1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD, 1'b1, OK0);
        check_mem("sh", 1'b1, 32'h0000_0004, 4'b1100, 32'hABCD_ABCD);
        serve("sh", 3, 0, 32'h0);

        issue(1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 1'b1, OK0);
        check_mem("sb", 1'b1, 32'h0000_0000, 4'b0010, 32'hA5A5_A5A5);
        serve("sb", 1, 0, 32'h0);

        // Error path: misaligned word, reserved funct3, unsigned store width
        illegal("lw_mis",  1'b0, 3'b010, 32'h0000_0002);
        illegal("f3_011",  1'b0, 3'b011, 32'h0000_0000);
        illegal("sbu",     1'b1, 3'b100, 32'h0000_0000);

        // Timeout: memory never answers
        issue(1'b0, 3'b010, 32'h0000_0020, 32'h0, 1'b1, '{rdata: 32'd0, mis: 1'b0, to: 1'b1});
        en_cnt = 0;
        while (bus.mem_enable === 1'b1 && en_cnt < 50) begin
            en_cnt++;
            @(negedge clk);
        end
        check("tmo_enable_cycles", 32'(en_cnt), 32'(TMO));
        check("tmo_ready_low",     32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("tmo_ready_back",    32'(bus.req_ready), 32'd1);

        // Reset while in REQ: enable drops at once, no response
        issue(1'b0, 3'b010, 32'h0000_0040, 32'h0, 1'b0, OK0);
        check("rreq_enable", 32'(bus.mem_enable), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rreq_enable_drop", 32'(bus.mem_enable), 32'd0);
        check("rreq_ready",       32'(bus.req_ready),  32'd0);
        check("rreq_resp_valid",  32'(bus.resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rreq_ready_after", 32'(bus.req_ready), 32'd1);

        // LW after reset, memory holds mem_valid three extra cycles
        issue(1'b0, 3'b010, 32'h0000_0044, 32'h0, 1'b1, '{rdata: 32'hDEAD_BEEF, mis: 1'b0, to: 1'b0});
        check_mem("lw", 1'b0, 32'h0000_0044, 4'b1111, 32'h0);
        serve("lw", 2, 3, 32'hDEAD_BEEF);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
